hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage MIPS core.
- Decodes the four stage instruction registers and drives the stall line and the D/E/M bypass selects that the datapath's bypass muxes consume.
- Tracks a multi-cycle multiply/divide unit with a busy counter and stalls dependent MD instructions.
- Sits beside the datapath as the control end of its stall/select interface.

Parameters:
MULT_CYCLES, 5, cycles mult/multu occupies the MD unit after leaving E
DIV_CYCLES, 10, cycles div/divu occupies the MD unit after leaving E
CNT_W, 4, width of the MD busy counter; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ir_d  in  32  instruction in D
ir_e  in  32  instruction in E
ir_m  in  32  instruction in M
ir_w  in  32  instruction in W
stall  out  1  1 = hold PC and F/D, insert bubble into E
rsd_sel  out  3  D rs bypass: 0 rf, 1 pc8_e, 2 aluout_m, 3 pc8_m, 4 wdata
rtd_sel  out  3  D rt bypass, same encoding as rsd_sel
rse_sel  out  3  E rs bypass: 0 reg, 1 aluout_m, 2 pc8_m, 3 wdata
rte_sel  out  3  E rt bypass, same encoding as rse_sel
rtm_sel  out  3  M store-data bypass: 0 rt_m, 1 wdata
md_start  out  1  mult/div present in E this cycle (unit starts at next edge)
md_busy  out  1  MD counter nonzero
stall_cycles  out  32  stall cycle count (see Optional Feature)

Behaviour:
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo, nop (all-zero). Anything else decodes as no read, no write.
- Destination register: R-type ALU ops and mfhi/mflo write rd; ori, lui, lw write rt; jal writes 31. A destination of 0 counts as no write.
- Tnew in E: jal 0, ALU/mf 1, lw 2. Tnew in M: ALU/mf/jal 0, lw 1. Tnew in W: 0.
- Tuse:
  - beq rs/rt = 0; jr rs = 0.
  - ALU rs/rt, lw rs, sw rs, MD rs/rt, mt rs = 1.
  - sw rt = 2.
- Data stall: assert when a source read in D matches a nonzero destination in E or M with Tnew(stage) > Tuse.
- MD stall: assert when D holds any MD-class op (mult*, div*, mf*, mt*) and either md_busy=1 or md_start=1.
- stall is the OR of the data stall and the MD stall.
- Forward priority is nearest stage first. A register number of 0 always selects source 0.
- D selects:
  - E jal with matching destination -> 1.
  - Else M ALU/mf op -> 2; M jal -> 3.
  - Else W writer -> 4.
- E selects: M ALU/mf -> 1; M jal -> 2; W writer -> 3.
- rtm_sel = 1 when M holds sw and W writes rt_m's register (nonzero).
- A select only forwards from a stage whose value is ready (Tnew = 0). Otherwise the stall covers the hazard and the select stays at 0.
- Busy counter (sequential, the only state):
  - On reset low: counter = 0.
  - At a clock edge with md_start: load MULT_CYCLES or DIV_CYCLES.
  - Otherwise, if nonzero, decrement by 1.
  - md_busy = (counter != 0).
  - md_start while busy cannot occur, since the stall prevents it. If forced, reload (later op wins).
- Reset values:
  - With ir_* all zero, all outputs are 0 and the counter is 0.
  - Reset asserted mid-MD-operation clears the counter immediately (async), not waiting for a clock edge.
- All selects and stall are combinational from ir_* and the counter. There is no added latency.

Optional Feature:
- Macro HAZARD_STALL_CNT_EN.
- When defined: a 32-bit register counts clock edges with stall=1. It clears on reset and wraps from 0xFFFFFFFF to 0. stall_cycles is that register.
- When undefined: no counter is built and stall_cycles is tied to 0.

Test Plan:
- lw $1,0($0) in E, addu $2,$1,$3 in D -> stall=1 for 1 cycle; then with lw in W, rse_sel=3 and stall=0.
- ori $5,$0,7 in M, beq $5,$5 in D -> stall=0, rsd_sel=2, rtd_sel=2.
- jal in E, jr $31 in D -> rsd_sel=1, stall=0. With addu $0 writer in M, rsd_sel stays 0.
- lw $4 in W, sw $4,0($0) in M -> rtm_sel=1.
- mult in E, mflo in D -> md_start=1, stall=1. Counter reads 5,4,3,2,1,0 on successive edges; stall drops when the counter reaches 0. Pulling reset low mid-count -> md_busy=0 immediately.
- With HAZARD_STALL_CNT_EN, 3 stall cycles -> stall_cycles=3. Without the macro -> stall_cycles=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : hazard_ctrl
// Brief    : Stall and bypass-select control for the 5-stage MIPS pipeline,
//            with a busy counter for the multi-cycle multiply/divide unit.
//            Define HAZARD_STALL_CNT_EN to build the 32-bit stall-cycle counter.
// Revision : 1.0 - initial release
//==============================================================================
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir_d,
    input  logic [31:0] ir_e,
    input  logic [31:0] ir_m,
    input  logic [31:0] ir_w,
    output logic        stall,
    output logic [2:0]  rsd_sel,
    output logic [2:0]  rtd_sel,
    output logic [2:0]  rse_sel,
    output logic [2:0]  rte_sel,
    output logic [2:0]  rtm_sel,
    output logic        md_start,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_ori   = 6'h0d;
    localparam logic [5:0] c_op_lui   = 6'h0f;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2b;

    localparam logic [5:0] c_fn_jr    = 6'h08;
    localparam logic [5:0] c_fn_mfhi  = 6'h10;
    localparam logic [5:0] c_fn_mthi  = 6'h11;
    localparam logic [5:0] c_fn_mflo  = 6'h12;
    localparam logic [5:0] c_fn_mtlo  = 6'h13;
    localparam logic [5:0] c_fn_mult  = 6'h18;
    localparam logic [5:0] c_fn_multu = 6'h19;
    localparam logic [5:0] c_fn_div   = 6'h1a;
    localparam logic [5:0] c_fn_divu  = 6'h1b;
    localparam logic [5:0] c_fn_addu  = 6'h21;
    localparam logic [5:0] c_fn_subu  = 6'h23;

    localparam logic [4:0]       c_reg_ra    = 5'd31;
    localparam logic [CNT_W-1:0] c_mult_load = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        CLS_NONE, CLS_ALU, CLS_LW, CLS_SW, CLS_BEQ, CLS_J, CLS_JAL,
        CLS_JR, CLS_MULT, CLS_DIV, CLS_MF, CLS_MT
    } cls_t;

    typedef struct packed {
        cls_t       cls;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       rs_rd;
        logic       rt_rd;
        logic [1:0] rs_tuse;
        logic [1:0] rt_tuse;
        logic [1:0] tnew_e;
        logic [1:0] tnew_m;
    } dec_t;

    // Destination 0 doubles as "no write", so writers to $0 never match a source.
    function automatic dec_t decode(
        input logic [5:0] op,
        input logic [5:0] fn,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd
    );
        dec_t d;
        d     = '0;
        d.rs  = rs;
        d.rt  = rt;
        case (op)
            c_op_rtype: begin
                case (fn)
                    c_fn_addu, c_fn_subu: begin
                        d.cls     = CLS_ALU;
                        d.rs_rd   = 1'b1;
                        d.rt_rd   = 1'b1;
                        d.rs_tuse = 2'd1;
                        d.rt_tuse = 2'd1;
                        d.dst     = rd;
                        d.tnew_e  = 2'd1;
                    end
                    c_fn_jr: begin
                        d.cls   = CLS_JR;
                        d.rs_rd = 1'b1;
                    end
                    c_fn_mult, c_fn_multu, c_fn_div, c_fn_divu: begin
                        d.cls     = (fn == c_fn_mult || fn == c_fn_multu) ? CLS_MULT : CLS_DIV;
                        d.rs_rd   = 1'b1;
                        d.rt_rd   = 1'b1;
                        d.rs_tuse = 2'd1;
                        d.rt_tuse = 2'd1;
                    end
                    c_fn_mfhi, c_fn_mflo: begin
                        d.cls    = CLS_MF;
                        d.dst    = rd;
                        d.tnew_e = 2'd1;
                    end
                    c_fn_mthi, c_fn_mtlo: begin
                        d.cls     = CLS_MT;
                        d.rs_rd   = 1'b1;
                        d.rs_tuse = 2'd1;
                    end
                    default: ;
                endcase
            end
            c_op_ori: begin
                d.cls     = CLS_ALU;
                d.rs_rd   = 1'b1;
                d.rs_tuse = 2'd1;
                d.dst     = rt;
                d.tnew_e  = 2'd1;
            end
            c_op_lui: begin
                d.cls    = CLS_ALU;
                d.dst    = rt;
                d.tnew_e = 2'd1;
            end
            c_op_lw: begin
                d.cls     = CLS_LW;
                d.rs_rd   = 1'b1;
                d.rs_tuse = 2'd1;
                d.dst     = rt;
                d.tnew_e  = 2'd2;
            end
            c_op_sw: begin
                d.cls     = CLS_SW;
                d.rs_rd   = 1'b1;
                d.rt_rd   = 1'b1;
                d.rs_tuse = 2'd1;
                d.rt_tuse = 2'd2;
            end
            c_op_beq: begin
                d.cls   = CLS_BEQ;
                d.rs_rd = 1'b1;
                d.rt_rd = 1'b1;
            end
            c_op_j:   d.cls = CLS_J;
            c_op_jal: begin
                d.cls = CLS_JAL;
                d.dst = c_reg_ra;
            end
            default: ;
        endcase
        d.tnew_m = (d.tnew_e == 2'd0) ? 2'd0 : d.tnew_e - 2'd1;
        return d;
    endfunction

    function automatic logic src_stall(
        input logic       rd,
        input logic [4:0] r,
        input logic [1:0] tuse,
        input logic [4:0] e_dst,
        input logic [1:0] e_tnew,
        input logic [4:0] m_dst,
        input logic [1:0] m_tnew
    );
        return rd && (r != 5'd0) &&
               (((e_dst == r) && (e_tnew > tuse)) || ((m_dst == r) && (m_tnew > tuse)));
    endfunction

    // Nearest matching stage decides; an unready match blocks older stages too.
    function automatic logic [2:0] fwd_d(
        input logic       rd,
        input logic [4:0] r,
        input logic [4:0] e_dst,
        input logic       e_jal,
        input logic [4:0] m_dst,
        input logic       m_jal,
        input logic       m_ready,
        input logic [4:0] w_dst
    );
        logic [2:0] sel;
        sel = 3'd0;
        if (rd && (r != 5'd0)) begin
            if (e_dst == r)
                sel = e_jal ? 3'd1 : 3'd0;
            else if (m_dst == r)
                sel = m_jal ? 3'd3 : (m_ready ? 3'd2 : 3'd0);
            else if (w_dst == r)
                sel = 3'd4;
        end
        return sel;
    endfunction

    function automatic logic [2:0] fwd_e(
        input logic       rd,
        input logic [4:0] r,
        input logic [4:0] m_dst,
        input logic       m_jal,
        input logic       m_ready,
        input logic [4:0] w_dst
    );
        logic [2:0] sel;
        sel = 3'd0;
        if (rd && (r != 5'd0)) begin
            if (m_dst == r)
                sel = m_jal ? 3'd2 : (m_ready ? 3'd1 : 3'd0);
            else if (w_dst == r)
                sel = 3'd3;
        end
        return sel;
    endfunction

    dec_t             w_dec_d;
    dec_t             w_dec_e;
    dec_t             w_dec_m;
    dec_t             w_dec_w;
    logic             w_e_jal;
    logic             w_m_jal;
    logic             w_m_ready;
    logic             w_data_stall;
    logic             w_d_is_md;
    logic             w_md_stall;
    logic             w_unused;
    logic [CNT_W-1:0] r_md_cnt;

    assign w_dec_d = decode(ir_d[31:26], ir_d[5:0], ir_d[25:21], ir_d[20:16], ir_d[15:11]);
    assign w_dec_e = decode(ir_e[31:26], ir_e[5:0], ir_e[25:21], ir_e[20:16], ir_e[15:11]);
    assign w_dec_m = decode(ir_m[31:26], ir_m[5:0], ir_m[25:21], ir_m[20:16], ir_m[15:11]);
    assign w_dec_w = decode(ir_w[31:26], ir_w[5:0], ir_w[25:21], ir_w[20:16], ir_w[15:11]);

    assign w_e_jal   = (w_dec_e.cls == CLS_JAL);
    assign w_m_jal   = (w_dec_m.cls == CLS_JAL);
    assign w_m_ready = (w_dec_m.tnew_m == 2'd0);

    assign w_data_stall =
        src_stall(w_dec_d.rs_rd, w_dec_d.rs, w_dec_d.rs_tuse,
                  w_dec_e.dst, w_dec_e.tnew_e, w_dec_m.dst, w_dec_m.tnew_m) |
        src_stall(w_dec_d.rt_rd, w_dec_d.rt, w_dec_d.rt_tuse,
                  w_dec_e.dst, w_dec_e.tnew_e, w_dec_m.dst, w_dec_m.tnew_m);

    assign w_d_is_md  = (w_dec_d.cls == CLS_MULT) || (w_dec_d.cls == CLS_DIV) ||
                        (w_dec_d.cls == CLS_MF)   || (w_dec_d.cls == CLS_MT);
    assign md_start   = (w_dec_e.cls == CLS_MULT) || (w_dec_e.cls == CLS_DIV);
    assign md_busy    = (r_md_cnt != '0);
    assign w_md_stall = w_d_is_md && (md_busy || md_start);
    assign stall      = w_data_stall | w_md_stall;

    assign rsd_sel = fwd_d(w_dec_d.rs_rd, w_dec_d.rs, w_dec_e.dst, w_e_jal,
                           w_dec_m.dst, w_m_jal, w_m_ready, w_dec_w.dst);
    assign rtd_sel = fwd_d(w_dec_d.rt_rd, w_dec_d.rt, w_dec_e.dst, w_e_jal,
                           w_dec_m.dst, w_m_jal, w_m_ready, w_dec_w.dst);
    assign rse_sel = fwd_e(w_dec_e.rs_rd, w_dec_e.rs, w_dec_m.dst, w_m_jal,
                           w_m_ready, w_dec_w.dst);
    assign rte_sel = fwd_e(w_dec_e.rt_rd, w_dec_e.rt, w_dec_m.dst, w_m_jal,
                           w_m_ready, w_dec_w.dst);
    assign rtm_sel = {2'b00, (w_dec_m.cls == CLS_SW) && (w_dec_m.rt != 5'd0) &&
                             (w_dec_w.dst == w_dec_m.rt)};

    // A start while already busy reloads: the most recent MD op defines the wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_md_cnt <= '0;
        else if (md_start)
            r_md_cnt <= (w_dec_e.cls == CLS_MULT) ? c_mult_load : c_div_load;
        else if (r_md_cnt != '0)
            r_md_cnt <= r_md_cnt - c_cnt_one;
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stall_cnt <= 32'd0;
        else if (stall)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = 32'd0;
`endif

    assign w_unused = ^{w_dec_d, w_dec_e, w_dec_m, w_dec_w,
                        ir_d[10:6], ir_e[10:6], ir_m[10:6], ir_w[10:6]};

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl: directed pipeline scenarios
//            plus random instruction mixes against a mnemonic-level model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_hazard_ctrl;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic [31:0] ir_d   = '0;
    logic [31:0] ir_e   = '0;
    logic [31:0] ir_m   = '0;
    logic [31:0] ir_w   = '0;
    logic        stall;
    logic [2:0]  rsd_sel;
    logic [2:0]  rtd_sel;
    logic [2:0]  rse_sel;
    logic [2:0]  rte_sel;
    logic [2:0]  rtm_sel;
    logic        md_start;
    logic        md_busy;
    logic [31:0] stall_cycles;

    int          errors   = 0;
    int          checks   = 0;
    int          mdl_cnt  = 0;
    logic [31:0] mdl_scnt = '0;

    string names [19] = '{"addu", "subu", "ori", "lui", "lw", "sw", "beq", "j", "jal", "jr",
                          "mult", "multu", "div", "divu", "mfhi", "mflo", "mthi", "mtlo", "nop"};
    int    regs  [5]  = '{0, 1, 2, 3, 31};

    hazard_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10),
        .CNT_W      (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ir_d        (ir_d),
        .ir_e        (ir_e),
        .ir_m        (ir_m),
        .ir_w        (ir_w),
        .stall       (stall),
        .rsd_sel     (rsd_sel),
        .rtd_sel     (rtd_sel),
        .rse_sel     (rse_sel),
        .rte_sel     (rte_sel),
        .rtm_sel     (rtm_sel),
        .md_start    (md_start),
        .md_busy     (md_busy),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // ---------------- instruction encoder ----------------
    function automatic logic [31:0] enc(string n, int rs, int rt, int rd);
        logic [4:0] s;
        logic [4:0] t;
        logic [4:0] d;
        s = 5'(rs);
        t = 5'(rt);
        d = 5'(rd);
        if (n == "addu")  return {6'h00, s, t, d, 5'h00, 6'h21};
        if (n == "subu")  return {6'h00, s, t, d, 5'h00, 6'h23};
        if (n == "jr")    return {6'h00, s, 5'd0, 5'd0, 5'h00, 6'h08};
        if (n == "mult")  return {6'h00, s, t, 5'd0, 5'h00, 6'h18};
        if (n == "multu") return {6'h00, s, t, 5'd0, 5'h00, 6'h19};
        if (n == "div")   return {6'h00, s, t, 5'd0, 5'h00, 6'h1a};
        if (n == "divu")  return {6'h00, s, t, 5'd0, 5'h00, 6'h1b};
        if (n == "mfhi")  return {6'h00, 5'd0, 5'd0, d, 5'h00, 6'h10};
        if (n == "mflo")  return {6'h00, 5'd0, 5'd0, d, 5'h00, 6'h12};
        if (n == "mthi")  return {6'h00, s, 5'd0, 5'd0, 5'h00, 6'h11};
        if (n == "mtlo")  return {6'h00, s, 5'd0, 5'd0, 5'h00, 6'h13};
        if (n == "ori")   return {6'h0d, s, t, 16'h0007};
        if (n == "lui")   return {6'h0f, 5'd0, t, 16'h0004};
        if (n == "lw")    return {6'h23, s, t, 16'h0000};
        if (n == "sw")    return {6'h2b, s, t, 16'h0000};
        if (n == "beq")   return {6'h04, s, t, 16'h0004};
        if (n == "j")     return {6'h02, 26'h0000010};
        if (n == "jal")   return {6'h03, 26'h0000020};
        return 32'h0;
    endfunction

    // ---------------- reference model ----------------
    function automatic string m_name(logic [31:0] ir);
        logic [5:0] op;
        logic [5:0] fn;
        op = ir[31:26];
        fn = ir[5:0];
        if (op == 6'h00) begin
            case (fn)
                6'h21: return "addu";
                6'h23: return "subu";
                6'h08: return "jr";
                6'h18: return "mult";
                6'h19: return "multu";
                6'h1a: return "div";
                6'h1b: return "divu";
                6'h10: return "mfhi";
                6'h12: return "mflo";
                6'h11: return "mthi";
                6'h13: return "mtlo";
                default: return "none";
            endcase
        end
        case (op)
            6'h0d: return "ori";
            6'h0f: return "lui";
            6'h23: return "lw";
            6'h2b: return "sw";
            6'h04: return "beq";
            6'h02: return "j";
            6'h03: return "jal";
            default: return "none";
        endcase
    endfunction

    function automatic int m_reg(logic [31:0] ir, int which);
        return (which == 0) ? int'(ir[25:21]) : int'(ir[20:16]);
    endfunction

    function automatic int m_dst(logic [31:0] ir);
        string n;
        n = m_name(ir);
        if (n == "addu" || n == "subu" || n == "mfhi" || n == "mflo") return int'(ir[15:11]);
        if (n == "ori" || n == "lui" || n == "lw") return int'(ir[20:16]);
        if (n == "jal") return 31;
        return 0;
    endfunction

    // stage: 0 = E, 1 = M, 2 = W
    function automatic int m_tnew(logic [31:0] ir, int stage);
        string n;
        n = m_name(ir);
        if (stage == 2) return 0;
        if (n == "lw") return (stage == 0) ? 2 : 1;
        if (n == "jal") return 0;
        return (stage == 0) ? 1 : 0;
    endfunction

    // -1 means the field is not read
    function automatic int m_tuse(logic [31:0] ir, int which);
        string n;
        n = m_name(ir);
        if (n == "beq") return 0;
        if (which == 0) begin
            if (n == "jr") return 0;
            if (n == "addu" || n == "subu" || n == "ori" || n == "lw" || n == "sw" ||
                n == "mult" || n == "multu" || n == "div" || n == "divu" ||
                n == "mthi" || n == "mtlo") return 1;
        end else begin
            if (n == "sw") return 2;
            if (n == "addu" || n == "subu" || n == "mult" || n == "multu" ||
                n == "div" || n == "divu") return 1;
        end
        return -1;
    endfunction

    function automatic bit m_start(logic [31:0] ir);
        string n;
        n = m_name(ir);
        return (n == "mult" || n == "multu" || n == "div" || n == "divu");
    endfunction

    function automatic bit m_mdclass(logic [31:0] ir);
        string n;
        n = m_name(ir);
        return m_start(ir) || n == "mfhi" || n == "mflo" || n == "mthi" || n == "mtlo";
    endfunction

    function automatic int m_load(logic [31:0] ir);
        string n;
        n = m_name(ir);
        return (n == "mult" || n == "multu") ? 5 : 10;
    endfunction

    function automatic bit m_stall(logic [31:0] d, logic [31:0] e, logic [31:0] m, int cnt);
        for (int s = 0; s < 2; s++) begin
            int t;
            int r;
            t = m_tuse(d, s);
            r = m_reg(d, s);
            if (t >= 0 && r != 0) begin
                if (m_dst(e) == r && m_tnew(e, 0) > t) return 1'b1;
                if (m_dst(m) == r && m_tnew(m, 1) > t) return 1'b1;
            end
        end
        return m_mdclass(d) && (cnt != 0 || m_start(e));
    endfunction

    function automatic int m_dsel(logic [31:0] d, int s, logic [31:0] e, logic [31:0] m, logic [31:0] w);
        int r;
        r = m_reg(d, s);
        if (m_tuse(d, s) < 0 || r == 0) return 0;
        if (m_dst(e) == r) return (m_name(e) == "jal") ? 1 : 0;
        if (m_dst(m) == r) begin
            if (m_tnew(m, 1) != 0) return 0;
            return (m_name(m) == "jal") ? 3 : 2;
        end
        if (m_dst(w) == r) return 4;
        return 0;
    endfunction

    function automatic int m_esel(logic [31:0] e, int s, logic [31:0] m, logic [31:0] w);
        int r;
        r = m_reg(e, s);
        if (m_tuse(e, s) < 0 || r == 0) return 0;
        if (m_dst(m) == r) begin
            if (m_tnew(m, 1) != 0) return 0;
            return (m_name(m) == "jal") ? 2 : 1;
        end
        if (m_dst(w) == r) return 3;
        return 0;
    endfunction

    function automatic int m_rtm(logic [31:0] m, logic [31:0] w);
        int r;
        r = m_reg(m, 1);
        return (m_name(m) == "sw" && r != 0 && m_dst(w) == r) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdl_cnt  <= 0;
            mdl_scnt <= '0;
        end else begin
            if (m_stall(ir_d, ir_e, ir_m, mdl_cnt)) mdl_scnt <= mdl_scnt + 32'd1;
            if (m_start(ir_e))     mdl_cnt <= m_load(ir_e);
            else if (mdl_cnt > 0)  mdl_cnt <= mdl_cnt - 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(logic [31:0] d, logic [31:0] e, logic [31:0] m, logic [31:0] w);
        ir_d = d;
        ir_e = e;
        ir_m = m;
        ir_w = w;
    endtask

    function automatic logic [31:0] rnd_ir();
        if ($urandom_range(0, 9) == 0) return $urandom;
        return enc(names[$urandom_range(0, 18)], regs[$urandom_range(0, 4)],
                   regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)]);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        put('0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b want 0", stall);
        end
        checks++;
        if ({rsd_sel, rtd_sel, rse_sel, rte_sel, rtm_sel} !== 15'd0) begin
            errors++; $display("FAIL reset_sels: got %h want 0", {rsd_sel, rtd_sel, rse_sel, rte_sel, rtm_sel});
        end
        checks++;
        if ({md_start, md_busy} !== 2'b00) begin
            errors++; $display("FAIL reset_md: got %b want 00", {md_start, md_busy});
        end
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles);
        end
        reset = 1'b1;
    endtask

    task automatic test_load_use();
        tick();
        put(enc("addu", 1, 3, 2), enc("lw", 0, 1, 0), '0, '0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL loaduse_stall_e: got %b want 1", stall);
        end
        tick();
        put(enc("addu", 1, 3, 2), '0, enc("lw", 0, 1, 0), '0);
        @(negedge clk);
        checks++;
        if ({stall, rsd_sel} !== 4'b0_000) begin
            errors++; $display("FAIL loaduse_m: got stall=%b rsd=%0d want 0/0", stall, rsd_sel);
        end
        tick();
        put('0, enc("addu", 1, 3, 2), '0, enc("lw", 0, 1, 0));
        @(negedge clk);
        checks++;
        if (rse_sel !== 3'd3 || stall !== 1'b0) begin
            errors++; $display("FAIL loaduse_w: got rse=%0d stall=%b want 3/0", rse_sel, stall);
        end
    endtask

    task automatic test_branch();
        tick();
        put(enc("beq", 5, 5, 0), '0, enc("ori", 0, 5, 0), '0);
        @(negedge clk);
        checks++;
        if ({stall, rsd_sel, rtd_sel} !== {1'b0, 3'd2, 3'd2}) begin
            errors++; $display("FAIL branch_fwd_m: got stall=%b rsd=%0d rtd=%0d want 0/2/2", stall, rsd_sel, rtd_sel);
        end
    endtask

    task automatic test_jal();
        tick();
        put(enc("jr", 31, 0, 0), enc("jal", 0, 0, 0), '0, '0);
        @(negedge clk);
        checks++;
        if (rsd_sel !== 3'd1 || stall !== 1'b0) begin
            errors++; $display("FAIL jal_e_fwd: got rsd=%0d stall=%b want 1/0", rsd_sel, stall);
        end
        tick();
        put(enc("jr", 31, 0, 0), '0, enc("jal", 0, 0, 0), '0);
        @(negedge clk);
        checks++;
        if (rsd_sel !== 3'd3) begin
            errors++; $display("FAIL jal_m_fwd: got rsd=%0d want 3", rsd_sel);
        end
        tick();
        put(enc("addu", 0, 0, 3), '0, enc("addu", 1, 2, 0), '0);
        @(negedge clk);
        checks++;
        if ({rsd_sel, rtd_sel} !== 6'd0) begin
            errors++; $display("FAIL zero_reg: got rsd=%0d rtd=%0d want 0/0", rsd_sel, rtd_sel);
        end
    endtask

    task automatic test_store();
        tick();
        put('0, '0, enc("sw", 0, 4, 0), enc("lw", 0, 4, 0));
        @(negedge clk);
        checks++;
        if (rtm_sel !== 3'd1) begin
            errors++; $display("FAIL store_fwd: got rtm=%0d want 1", rtm_sel);
        end
        tick();
        put('0, '0, enc("sw", 0, 4, 0), enc("lw", 0, 5, 0));
        @(negedge clk);
        checks++;
        if (rtm_sel !== 3'd0) begin
            errors++; $display("FAIL store_nofwd: got rtm=%0d want 0", rtm_sel);
        end
    endtask

    task automatic test_md();
        tick();
        put(enc("mflo", 0, 0, 3), enc("mult", 1, 2, 0), '0, '0);
        @(negedge clk);
        checks++;
        if ({md_start, stall, md_busy} !== 3'b110) begin
            errors++; $display("FAIL md_start: got start/stall/busy=%b want 110", {md_start, stall, md_busy});
        end
        for (int k = 5; k >= 0; k--) begin
            tick();
            put(enc("mflo", 0, 0, 3), '0, '0, '0);
            @(negedge clk);
            checks++;
            if (md_busy !== (k != 0) || stall !== (k != 0) || md_start !== 1'b0) begin
                errors++;
                $display("FAIL md_count_%0d: got busy=%b stall=%b start=%b want %b/%b/0",
                         k, md_busy, stall, md_start, k != 0, k != 0);
            end
        end
        tick();
        put('0, enc("div", 1, 2, 0), '0, '0);
        tick();
        put('0, '0, '0, '0);
        tick();
        @(negedge clk);
        checks++;
        if (md_busy !== 1'b1) begin
            errors++; $display("FAIL md_div_busy: got %b want 1", md_busy);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (md_busy !== 1'b0) begin
            errors++; $display("FAIL md_async_reset: got busy=%b want 0", md_busy);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_stall_cnt();
        logic [31:0] exp_cnt;
        @(negedge clk);
        put('0, '0, '0, '0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++; $display("FAIL stallcnt_clear: got %0d want 0", stall_cycles);
        end
        put(enc("addu", 1, 3, 2), enc("lw", 0, 1, 0), '0, '0);
        repeat (3) @(posedge clk);
        #1 put('0, '0, '0, '0);
        @(negedge clk);
`ifdef HAZARD_STALL_CNT_EN
        exp_cnt = 32'd3;
`else
        exp_cnt = 32'd0;
`endif
        checks++;
        if (stall_cycles !== exp_cnt) begin
            errors++; $display("FAIL stallcnt_three: got %0d want %0d", stall_cycles, exp_cnt);
        end
    endtask

    task automatic test_random();
        string       nm  [9] = '{"stall", "rsd_sel", "rtd_sel", "rse_sel", "rte_sel",
                                 "rtm_sel", "md_start", "md_busy", "stall_cycles"};
        logic [31:0] obs [9];
        logic [31:0] exv [9];
        for (int i = 0; i < 400; i++) begin
            tick();
            put(rnd_ir(), rnd_ir(), rnd_ir(), rnd_ir());
            @(negedge clk);
            obs[0] = {31'd0, stall};
            obs[1] = {29'd0, rsd_sel};
            obs[2] = {29'd0, rtd_sel};
            obs[3] = {29'd0, rse_sel};
            obs[4] = {29'd0, rte_sel};
            obs[5] = {29'd0, rtm_sel};
            obs[6] = {31'd0, md_start};
            obs[7] = {31'd0, md_busy};
            obs[8] = stall_cycles;
            exv[0] = m_stall(ir_d, ir_e, ir_m, mdl_cnt) ? 32'd1 : 32'd0;
            exv[1] = m_dsel(ir_d, 0, ir_e, ir_m, ir_w);
            exv[2] = m_dsel(ir_d, 1, ir_e, ir_m, ir_w);
            exv[3] = m_esel(ir_e, 0, ir_m, ir_w);
            exv[4] = m_esel(ir_e, 1, ir_m, ir_w);
            exv[5] = m_rtm(ir_m, ir_w);
            exv[6] = m_start(ir_e) ? 32'd1 : 32'd0;
            exv[7] = (mdl_cnt != 0) ? 32'd1 : 32'd0;
`ifdef HAZARD_STALL_CNT_EN
            exv[8] = mdl_scnt;
`else
            exv[8] = 32'd0;
`endif
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (obs[k] !== exv[k]) begin
                    errors++;
                    $display("FAIL rand_%s cycle %0d: got %0d want %0d (d=%h e=%h m=%h w=%h)",
                             nm[k], i, obs[k], exv[k], ir_d, ir_e, ir_m, ir_w);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_jal();
        test_store();
        test_md();
        test_stall_cnt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
